instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the single-cycle datapath. Replaces the zero-latency combinational instruction-memory lookup with a request/response memory port.
- Holds the PC and issues in-order word fetches to instruction memory. Buffers returned words in a small prefetch FIFO and presents one instruction plus its PC per cycle under valid/ready.
- Accepts PC redirects from the datapath (taken branch, JAL, JALR) and squashes stale fetches.

Parameters:
- PC_W, 9, PC / instruction address width in bits (byte address).
- INS_W, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries; power of two, min 2.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  global clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- imem_req  out  1  fetch request valid
- imem_addr  out  PC_W  fetch byte address, bits [1:0] always 0
- imem_ready  in  1  memory accepts request this cycle (handshake = imem_req & imem_ready)
- imem_rvalid  in  1  response valid; responses in request order, latency >= 1 cycle, unbounded
- imem_rdata  in  INS_W  response instruction word
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  PC_W  redirect target; bits [1:0] ignored, treated as 0
- instr_valid  out  1  instr / instr_pc valid
- instr_ready  in  1  datapath consumes instruction (pop = instr_valid & instr_ready)
- instr  out  INS_W  instruction at FIFO head
- instr_pc  out  PC_W  PC of instr

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, fetch PC = RESET_PC, FIFO empty, outstanding = 0.
  - imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0.
  - A mid-operation reset drops all buffered and in-flight data. Responses arriving after reset deasserts are counted only if issued after reset.
- FSM states IDLE, RUN, FLUSH:
  - IDLE: first cycle after reset release. No request. Go to RUN.
  - RUN: imem_req = 1 iff outstanding + fifo_count < DEPTH (credit rule). FIFO can never overflow.
  - On a request handshake: fetch PC += 4, modulo 2^PC_W (0x1FC wraps to 0x000); outstanding += 1.
  - FLUSH: imem_req = 0. Each imem_rvalid is discarded and decrements outstanding. When outstanding reaches 0 (or is 0 on entry), go to RUN next cycle.
- Response in RUN/IDLE:
  - Push {imem_rdata, PC of that request} into the FIFO; outstanding -= 1.
  - A per-entry request-PC is tracked in a parallel DEPTH-deep queue written at issue.
- Output: instr / instr_pc are registered FIFO-head values. A response reaches instr_valid no earlier than the cycle after imem_rvalid (1-cycle buffer latency).
- Push and pop in the same cycle are both honoured; fifo_count is unchanged.
- Redirect (redirect_valid = 1, any state except IDLE):
  - Same cycle: FIFO flushed, instr_valid = 0 next cycle, fetch PC = {redirect_pc[PC_W-1:2], 2'b00}.
  - Request handshakes in the redirect cycle are suppressed: imem_req forced 0 that cycle.
  - If outstanding != 0 (after counting a response arriving in the same cycle, which is discarded), go to FLUSH; otherwise stay in/enter RUN.
  - A pop in the same cycle as a redirect is honoured by the datapath but the FIFO is still cleared.
  - A redirect during FLUSH updates the fetch PC and remains in FLUSH.
  - A redirect during IDLE is ignored.
- imem_addr always equals the fetch PC; it holds stable while imem_req = 1 and imem_ready = 0.
- Bubble: instr_valid = 0 whenever the FIFO is empty. The datapath must not advance its architectural state on invalid cycles.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Extra output port bubble_cnt (32 bits): counts cycles with state != IDLE and instr_valid = 0.
  - Extra output port squash_cnt (16 bits): counts responses discarded in FLUSH or on redirect.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then imem_ready = 1 with fixed 1-cycle latency, instr_ready = 1 -> requests at 0x000, 0x004, 0x008…; first instr_valid 2 cycles after the first handshake with instr_pc = 0x000; then one instruction per cycle with no gaps.
- instr_ready = 0 held, DEPTH = 4 -> exactly 4 handshakes, then imem_req = 0. Releasing instr_ready pops 0x000..0x00C in order, and requests resume at 0x010.
- 3 requests outstanding at latency 5; redirect_valid with redirect_pc = 0x103 -> state FLUSH, imem_req = 0 until the 3 responses are discarded, then the next request has imem_addr = 0x100 and the first instr_pc = 0x100. Under FETCH_PERF_CNT_EN, squash_cnt = 3.
- Fetch PC at 0x1FC -> next request address 0x000, and instr_pc wraps accordingly.
- imem_ready toggling 1,0,0,1 -> imem_addr held stable while stalled, no duplicate or skipped PC.
- Assert reset low mid-stream with 2 in flight and 3 buffered -> outputs immediately 0. After release, the first request is 0x000, and no pre-reset word appears on instr.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, request/response instruction-memory port, prefetch FIFO.
// Define FETCH_PERF_CNT_EN to add the bubble_cnt / squash_cnt counters.
module instr_fetch_unit #(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [INS_W-1:0] instr,
    output logic [PC_W-1:0]  instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      bubble_cnt,
    output logic [15:0]      squash_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [PC_W-1:0] ALIGN = {{(PC_W-2){1'b1}}, 2'b00};
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PC_W-1:0]  fetch_pc;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    out_after;
    logic [CW:0]      credit_sum;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rq_wr;
    logic [PW-1:0]    rq_rd;
    logic [INS_W-1:0] data_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem   [DEPTH];
    logic [PC_W-1:0]  req_pc_q [DEPTH];

    logic redir;
    logic rsp;
    logic credit_ok;
    logic hs;
    logic push;
    logic pop;

    // Qualified events; responses with nothing in flight are stale and ignored
    always_comb begin
        redir      = redirect_valid && (state_q != IDLE);
        rsp        = imem_rvalid && (outstanding != '0);
        credit_sum = {1'b0, outstanding} + {1'b0, fifo_count};
        credit_ok  = credit_sum < DEPTH_C;
        out_after  = outstanding - CW'(rsp);
    end

    // Next-state and request generation
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        unique case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (redir) begin
                    if (out_after != '0) state_d = FLUSH;
                end else begin
                    imem_req = credit_ok;
                end
            end
            FLUSH: begin
                if (!redir && (out_after == '0)) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hs          = imem_req && imem_ready;
    assign push        = rsp && (state_q == RUN) && !redir;
    assign pop         = instr_valid && instr_ready;
    assign imem_addr   = fetch_pc;
    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? data_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr] : '0;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Fetch PC: advance on accepted request, reload on redirect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     fetch_pc <= RESET_PC;
        else if (redir) fetch_pc <= redirect_pc & ALIGN;
        else if (hs)    fetch_pc <= fetch_pc + PC_STEP;
    end

    // In-flight request count, includes responses that will be squashed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) outstanding <= '0;
        else        outstanding <= outstanding + CW'(hs) - CW'(rsp);
    end

    // Request-PC queue pointers, written at issue and read at response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rq_wr <= '0;
            rq_rd <= '0;
        end else begin
            if (hs)  rq_wr <= rq_wr + PW'(1);
            if (rsp) rq_rd <= rq_rd + PW'(1);
        end
    end

    // Request-PC queue storage
    always_ff @(posedge clk) begin
        if (hs) req_pc_q[rq_wr] <= fetch_pc;
    end

    // Prefetch FIFO control; a redirect clears it regardless of pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else if (redir) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Prefetch FIFO storage: instruction word plus its request PC
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= req_pc_q[rq_rd];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating bubble and squash counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
            squash_cnt <= '0;
        end else begin
            if ((state_q != IDLE) && !instr_valid && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 32'd1;
            if (rsp && ((state_q == FLUSH) || redir) && (squash_cnt != '1))
                squash_cnt <= squash_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory timing, stalls, redirects and
// resets checked against a queue-based model of the fetch stream.
module tb_instr_fetch_unit;

    localparam int PC_W = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;
    localparam logic [PC_W-1:0] RESET_PC = '0;
    localparam logic [PC_W-1:0] ALIGN = 9'h1FC;

    typedef struct {
        logic [INS_W-1:0] data;
        logic [PC_W-1:0]  pc;
    } exp_t;

    typedef struct {
        logic [INS_W-1:0] data;
        int               due;
        bit               live;
    } rsp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ready;
    logic             imem_rvalid;
    logic [INS_W-1:0] imem_rdata;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             instr_valid;
    logic             instr_ready;
    logic [INS_W-1:0] instr;
    logic [PC_W-1:0]  instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]      bubble_cnt;
    logic [15:0]      squash_cnt;
`endif

    instr_fetch_unit #(
        .PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .bubble_cnt(bubble_cnt),
        .squash_cnt(squash_cnt)
`endif
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    rsp_t pend[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int serial = 0;
    int last_due = 0;
    int hs_cnt = 0;
    int first_hs = -1;
    int first_val = -1;
    int gaps = 0;
    int sq_model = 0;
    int pop_cnt = 0;
    int stall_cnt = 0;
    int rdy_mode = 0;
    int ir_mode = 1;
    int lat_min = 1;
    int lat_max = 1;
    bit release_pending = 0;
    bit in_idle = 0;
    bit redir_req = 0;
    bit track_first = 0;
    bit stall_prev = 0;
    bit have_last = 0;
    bit wrap_seen = 0;
    logic [PC_W-1:0] redir_target = '0;
    logic [PC_W-1:0] model_pc = RESET_PC;
    logic [PC_W-1:0] first_addr = '0;
    logic [PC_W-1:0] stall_addr = '0;
    logic [PC_W-1:0] last_hs_addr = '0;
    exp_t mon_e;

    function automatic void check(string name, logic [63:0] act,
                                  logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    // Model update for the cycle just driven, sampled before the next edge
    task automatic observe();
        bit hs;
        bit red;
        bit dead;
        rsp_t r;
        rsp_t n;
        exp_t e;
        int due;
        hs = imem_req && imem_ready;
        red = redirect_valid && !in_idle;
        dead = 0;
        foreach (pend[i]) if (!pend[i].live) dead = 1;
        if (stall_prev) begin
            stall_cnt++;
            check("addr_hold", imem_addr, stall_addr);
        end
        if (dead) check("flush_no_req", imem_req, 1'b0);
        if (in_idle) check("idle_no_req", imem_req, 1'b0);
        if (red) begin
            check("redirect_req_low", imem_req, 1'b0);
            model_pc = redirect_pc & ALIGN;
            exp_q.delete();
            foreach (pend[i]) pend[i].live = 0;
        end
        if (imem_rvalid) begin
            r = pend.pop_front();
            if (!r.live) sq_model++;
        end
        if (hs) begin
            check("imem_addr", imem_addr, model_pc);
            serial++;
            e.data = {16'(serial), 7'h00, model_pc};
            e.pc = model_pc;
            exp_q.push_back(e);
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            n.data = e.data;
            n.due = due;
            n.live = 1;
            pend.push_back(n);
            if (have_last && last_hs_addr == 9'h1FC && imem_addr == 9'h000)
                wrap_seen = 1;
            have_last = 1;
            last_hs_addr = imem_addr;
            model_pc = model_pc + 9'd4;
            hs_cnt++;
            if (first_hs < 0) first_hs = cyc;
            if (track_first) begin
                first_addr = imem_addr;
                track_first = 0;
            end
        end
        check("fifo_bound", exp_q.size() <= DEPTH, 1'b1);
        if (instr_valid && first_val < 0) first_val = cyc;
        if (first_val >= 0 && !instr_valid) gaps++;
        stall_prev = imem_req && !imem_ready && !red;
        stall_addr = imem_addr;
    endtask

    // One clock: drive inputs after the edge, observe before the next
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (release_pending) begin
            reset = 1'b1;
            in_idle = 1;
            release_pending = 0;
        end else begin
            in_idle = 0;
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata = pend[0].data;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata = $urandom;
        end
        case (rdy_mode)
            0: imem_ready = 1'b1;
            1: imem_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: imem_ready = ($urandom_range(0, 3) != 0);
        endcase
        case (ir_mode)
            0: instr_ready = 1'b0;
            1: instr_ready = 1'b1;
            default: instr_ready = ($urandom_range(0, 2) != 0);
        endcase
        if (in_idle) begin
            redirect_valid = 1'b1;
            redirect_pc = PC_W'($urandom);
        end else begin
            redirect_valid = redir_req;
            redirect_pc = redir_target;
        end
        redir_req = 0;
        @(negedge clk);
        #2;
        observe();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        imem_rvalid = 1'b0;
        imem_ready = 1'b0;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 9'h0);
        exp_q.delete();
        pend.delete();
        model_pc = RESET_PC;
        last_due = 0;
        stall_prev = 0;
        hs_cnt = 0;
        first_hs = -1;
        first_val = -1;
        gaps = 0;
        sq_model = 0;
        have_last = 0;
        repeat (2) @(posedge clk);
        release_pending = 1;
    endtask

    // Monitor: every pop is compared with the oldest expected entry
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
                pop_cnt++;
                check("pop_has_expect", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("instr", instr, mon_e.data);
                    check("instr_pc", instr_pc, mon_e.pc);
                end
            end
        end
    end

    initial begin
        int pops_before;
        reset = 1'b0;
        imem_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;

        rdy_mode = 0; ir_mode = 1; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (20) step();
        check("first_valid_latency", first_val - first_hs, 2);
        check("no_gaps", gaps, 0);

        ir_mode = 0;
        do_reset();
        repeat (12) step();
        check("credit_hs_count", hs_cnt, 4);
        check("credit_req_low", imem_req, 1'b0);
        ir_mode = 1;
        track_first = 1;
        repeat (12) step();
        check("resume_addr", first_addr, 9'h010);

        lat_min = 5; lat_max = 5;
        do_reset();
        for (int i = 0; i < 20 && hs_cnt < 3; i++) step();
        check("three_in_flight", hs_cnt, 3);
        redir_req = 1;
        redir_target = 9'h103;
        track_first = 1;
        step();
        repeat (25) step();
        check("redirect_first_addr", first_addr, 9'h100);
`ifdef FETCH_PERF_CNT_EN
        check("squash_cnt", squash_cnt, 16'd3);
`endif

        lat_min = 1; lat_max = 2;
        wrap_seen = 0;
        redir_req = 1;
        redir_target = 9'h1F4;
        repeat (20) step();
        check("pc_wrap", wrap_seen, 1'b1);

        rdy_mode = 1; lat_min = 1; lat_max = 3;
        stall_cnt = 0;
        repeat (40) step();
        check("stall_seen", stall_cnt > 0, 1'b1);

        rdy_mode = 0; ir_mode = 0; lat_min = 4; lat_max = 4;
        do_reset();
        repeat (8) step();
        check("pre_reset_buffered", instr_valid, 1'b1);
        do_reset();
        ir_mode = 1; lat_min = 1; lat_max = 1;
        track_first = 1;
        repeat (15) step();
        check("post_reset_first_addr", first_addr, 9'h000);

        rdy_mode = 2; ir_mode = 2; lat_min = 1; lat_max = 6;
        pops_before = pop_cnt;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                redir_req = 1;
                redir_target = PC_W'($urandom);
            end
            if ($urandom_range(0, 599) == 0) do_reset();
            step();
        end
        check("random_progress", (pop_cnt - pops_before) > 300, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
